// File: rtl/grid_pkg.sv
// Shared geometry, colour codes and arbiter state type
// for the board square map.
package grid_pkg;

  localparam int ROW_WIDTH   = 10;
  localparam int NUM_ROWS    = 20;
  localparam int MAP_WIDTH   = 14;
  localparam int ROW_START_X = 3;
  localparam int ROW_START_Y = 1;

  localparam logic [2:0] RED    = 3'd1;
  localparam logic [2:0] ORANGE = 3'd2;
  localparam logic [2:0] YELLOW = 3'd3;
  localparam logic [2:0] GREEN  = 3'd4;
  localparam logic [2:0] BLUE   = 3'd5;
  localparam logic [2:0] PURPLE = 3'd6;
  localparam logic [2:0] CYAN   = 3'd7;
  localparam int GHOST_BIT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ROW   = 2'd2,
    PIECE = 2'd3
  } state_t;

endpackage

// File: rtl/grid_cell_addr.sv
// Board (column,row) to square map address, with a
// visible-board range flag.
module grid_cell_addr
  import grid_pkg::*;
(
  input  logic [3:0] x,
  input  logic [4:0] y,
  output logic [8:0] addr,
  output logic       in_range
);

  // 9-bit arithmetic wraps exactly like truncating a wider result
  assign addr = (9'(y) + 9'(ROW_START_Y)) * 9'(MAP_WIDTH)
              + 9'(x) + 9'(ROW_START_X);

  assign in_range = (x < 4'(ROW_WIDTH)) && (y < 5'(NUM_ROWS));

endmodule

// File: rtl/grid_write_arbiter.sv
// Arbitrates clear/row/piece requesters onto the single
// square map write port as fixed-length write bursts.
module grid_write_arbiter
  import grid_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear_req,
  output logic        clear_ack,
  input  logic        row_req,
  input  logic [4:0]  row_idx,
  input  logic [39:0] row_data,
  output logic        row_ack,
  input  logic        piece_req,
  input  logic [15:0] piece_xs,
  input  logic [19:0] piece_ys,
  input  logic [3:0]  piece_color,
  output logic        piece_ack,
  output logic        busy,
  output logic        done,
  output logic        write_enable,
  output logic [8:0]  square_write_addr,
  output logic [3:0]  write_color
);

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  col;
  logic [4:0]  rowc;
  logic [4:0]  lat_row;
  logic [39:0] lat_data;
  logic [15:0] lat_xs;
  logic [19:0] lat_ys;
  logic [3:0]  lat_color;

  logic [3:0]  cx;
  logic [4:0]  cy;
  logic [3:0]  cc;
  logic [7:0]  last;
  logic [8:0]  caddr;
  logic        cin;

  grid_cell_addr u_addr (
    .x        (cx),
    .y        (cy),
    .addr     (caddr),
    .in_range (cin)
  );

  always_comb begin
    cx   = '0;
    cy   = '0;
    cc   = '0;
    last = '0;
    case (state)
      CLEAR: begin
        cx   = col;
        cy   = rowc;
        last = 8'(ROW_WIDTH * NUM_ROWS);
      end
      ROW: begin
        cx   = cnt[3:0];
        cy   = lat_row;
        cc   = lat_data[{cnt[3:0], 2'b00} +: 4];
        last = 8'(ROW_WIDTH);
      end
      PIECE: begin
        cx   = lat_xs[{cnt[1:0], 2'b00} +: 4];
        cc   = lat_color;
        last = 8'd4;
        case (cnt[1:0])
          2'd0:    cy = lat_ys[4:0];
          2'd1:    cy = lat_ys[9:5];
          2'd2:    cy = lat_ys[14:10];
          default: cy = lat_ys[19:15];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      cnt               <= '0;
      col               <= '0;
      rowc              <= '0;
      lat_row           <= '0;
      lat_data          <= '0;
      lat_xs            <= '0;
      lat_ys            <= '0;
      lat_color         <= '0;
      clear_ack         <= 1'b0;
      row_ack           <= 1'b0;
      piece_ack         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      write_enable      <= 1'b0;
      square_write_addr <= '0;
      write_color       <= '0;
    end else begin
      clear_ack         <= 1'b0;
      row_ack           <= 1'b0;
      piece_ack         <= 1'b0;
      done              <= 1'b0;
      write_enable      <= 1'b0;
      square_write_addr <= '0;
      write_color       <= '0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          col  <= '0;
          rowc <= '0;
          busy <= 1'b0;
          if (clear_req) begin
            state     <= CLEAR;
            clear_ack <= 1'b1;
            busy      <= 1'b1;
          end else if (row_req) begin
            state    <= ROW;
            row_ack  <= 1'b1;
            busy     <= 1'b1;
            lat_row  <= row_idx;
            lat_data <= row_data;
          end else if (piece_req) begin
            state     <= PIECE;
            piece_ack <= 1'b1;
            busy      <= 1'b1;
            lat_xs    <= piece_xs;
            lat_ys    <= piece_ys;
            lat_color <= piece_color;
          end
        end
        default: begin
          // one extra cycle after the last slot keeps busy
          // asserted through the final write
          if (cnt == last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            write_enable      <= cin;
            square_write_addr <= cin ? caddr : '0;
            write_color       <= cin ? cc : '0;
            cnt               <= cnt + 8'd1;
            if (col == 4'(ROW_WIDTH - 1)) begin
              col  <= '0;
              rowc <= rowc + 5'd1;
            end else begin
              col <= col + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/grid_write_arbiter.md
Name: grid_write_arbiter

Overview:
- Owns the single write port of the square map that the grid display reads each frame. Three requesters share it: board clear, row rewrite, and active/ghost piece draw.
- Each accepted request runs as one non-preemptive burst of back-to-back cell writes.
- Handles coordinate-to-address translation, so requesters deal only in (column, row) board coordinates.

Parameters:
- ROW_WIDTH, 10, visible board columns
- NUM_ROWS, 20, visible board rows
- MAP_WIDTH, 14, square map row pitch in cells
- ROW_START_X, 3, column offset of visible board inside the map
- ROW_START_Y, 1, row offset of visible board inside the map

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- clear_req  input  1  request to write colour 0 to all 200 visible cells
- clear_ack  output  1  one-cycle grant pulse for clear
- row_req  input  1  request to rewrite one visible row
- row_idx  input  5  row to rewrite, 0 = top
- row_data  input  40  ten 4-bit cell codes; bits [3:0] = column 0
- row_ack  output  1  one-cycle grant pulse for row
- piece_req  input  1  request to write four cells
- piece_xs  input  16  four 4-bit columns; cell k = bits [4k+3:4k]
- piece_ys  input  20  four 5-bit rows; cell k = bits [5k+4:5k]
- piece_color  input  4  code for all four cells: bit3 = ghost, [2:0] = colour, 0 = erase
- piece_ack  output  1  one-cycle grant pulse for piece
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse after the last write slot of a burst
- write_enable  output  1  square map write strobe
- square_write_addr  output  9  square map address
- write_color  output  4  square map data

Behaviour:
- All outputs are registered. On reset, every output is 0, the state is IDLE and the counters are 0.
- States:
  - IDLE: arbitrate.
  - CLEAR: 200 slots.
  - ROW: 10 slots.
  - PIECE: 4 slots.
- Arbitration runs only in IDLE. Fixed priority is clear > row > piece. Request inputs are sampled at the clock edge, and the payload of the winner is latched on that edge.
- Timing, taking the request as sampled at the end of cycle t and N as the slot count:
  - Winner's ack is high in cycle t+1, together with busy.
  - Write slots occupy cycles t+2 .. t+1+N, with no gaps.
  - busy stays high from t+1 through t+1+N.
  - done is high in cycle t+2+N; the state is IDLE in that cycle.
- A request still high during a burst is ignored. It is re-arbitrated in the first IDLE cycle, so a held request re-triggers. Requesters must drop req when they see ack.
- Payload inputs may change freely after the ack cycle.
- Slot order:
  - CLEAR: row-major, row 0 column 0 first, column index fastest.
  - ROW: columns 0..9.
  - PIECE: cells 0..3.
- Address = (y + ROW_START_Y) * MAP_WIDTH + x + ROW_START_X. Compute at full width and truncate to 9 bits; the maximum legal value is 292.
- Out-of-range cells (x ≥ ROW_WIDTH or y ≥ NUM_ROWS) keep their slot, so timing is fixed, but write_enable is 0 in that slot.
- row_idx ≥ NUM_ROWS: all 10 slots are suppressed; ack and done still occur.
- write_color: 0 during CLEAR, the latched nibble during ROW, latched piece_color during PIECE.
- address and colour are don't-care while write_enable is 0; drive them to 0.
- If reset is asserted mid-burst, the burst is abandoned: no done pulse and no further writes. Map contents already written are not restored.
- Simultaneous clear_req, row_req and piece_req: clear wins. The others wait and are then served in priority order on later IDLE cycles.

Decomposition:
- Package grid_pkg holds:
  - map geometry constants: ROW_WIDTH, NUM_ROWS, MAP_WIDTH, ROW_START_X, ROW_START_Y
  - 3-bit colour codes (RED=1 … CYAN=7) and the ghost bit index 3
  - state enum typedef {IDLE, CLEAR, ROW, PIECE}
- Sub-module grid_cell_addr: combinational, (x[3:0], y[4:0]) → {addr[8:0], in_range}. It is shared with the game logic's own collision map.

Test Plan:
- Reset, then piece_req with xs={4,5,4,5}, ys={0,0,1,1}, color=4'h3 → piece_ack in cycle t+1, writes to addresses 21, 22, 35, 36 with data 3 in cycles t+2..t+5, done in t+6.
- clear_req → exactly 200 consecutive writes of data 0. First address 17, last address 292, then done.
- row_req with row_idx=19, row_data=40'h76543_21076 → writes to addresses 283..292. Data nibbles are 6,7,0,1,2,3,4,5,6,7.
- clear_req, row_req and piece_req all high in the same cycle, each dropped on its ack → bursts run clear, then row, then piece. Ack pulses never overlap, and each ack follows the previous done by exactly one cycle.
- piece with cell 2 at x=12 → the slot-2 cycle has write_enable=0, the other three slots write, and done lands in t+6. row_idx=25 → 10 silent slots, then done.
- Reset during the 100th CLEAR slot → all outputs 0 on the next cycle, no done pulse. A new piece_req is served normally afterwards.
